// File: rtl/sar_adc_seq.sv
// Successive-approximation ADC sequencer.
// Drives the DAC trial code and the analog input mux, reads a clocked
// comparator through a 2-flop synchronizer and reports one result per
// conversion. Defining SAR_SCAN_MODE_EN compiles in round-robin scanning
// of all channels; without it every conversion is single-shot.
module sar_adc_seq #(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [CH_W-1:0]  ch_sel,
    input  logic             scan_en,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic [CH_W-1:0]  mux_sel,
    output logic             sample,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [CH_W-1:0]  result_ch
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_TRIAL  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    // Two extra cycles per trial let the synchronizer see the new DAC level.
    localparam logic [CNT_W-1:0] TRIAL_LAST  = CNT_W'(SETTLE_CYCLES + 1);
    localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(WIDTH - 1);
    localparam logic [CH_W:0]    CH_LIMIT    = (CH_W + 1)'(CHANNELS);
    localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(CHANNELS - 1);

    // Round-robin channel advance, wrapping after the last populated input.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        return (ch == CH_LAST) ? '0 : ch + 1'b1;
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] bit_idx;
    logic             cmp_p0;
    logic             cmp_p1;
    logic             scan_act;
    logic             scan_stop;
    logic             scan_req;
    logic             scan_go;
    logic             ch_ok;
    logic [WIDTH-1:0] trial_next;

`ifdef SAR_SCAN_MODE_EN
    assign scan_req = scan_en;
`else
    logic unused_scan_en;
    assign scan_req       = 1'b0;
    assign unused_scan_en = scan_en;
`endif

    assign ch_ok   = ({1'b0, ch_sel} < CH_LIMIT);
    assign busy    = (state != ST_IDLE);
    assign scan_go = scan_act && !scan_stop && scan_req;

    // Resolve the current trial bit and pre-set the next lower trial bit.
    always_comb begin
        trial_next = dac_code;
        if (!cmp_p1) begin
            trial_next[bit_idx] = 1'b0;
        end
        if (bit_idx != '0) begin
            trial_next[bit_idx - 1'b1] = 1'b1;
        end
    end

    // Synchronizer, conversion FSM and registered outputs; ena freezes all of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            cmp_p0    <= 1'b0;
            cmp_p1    <= 1'b0;
            dac_code  <= '0;
            mux_sel   <= '0;
            sample    <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_ch <= '0;
            scan_act  <= 1'b0;
            scan_stop <= 1'b0;
        end else if (ena) begin
            // stage p0 -> p1: comparator synchronizer
            cmp_p0 <= cmp_in;
            cmp_p1 <= cmp_p0;
            done   <= 1'b0;
            if (scan_act && (state != ST_IDLE) && !scan_req) begin
                scan_stop <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start && (scan_req || ch_ok)) begin
                        state     <= ST_SAMPLE;
                        mux_sel   <= scan_req ? '0 : ch_sel;
                        scan_act  <= scan_req;
                        scan_stop <= 1'b0;
                        sample    <= 1'b1;
                        dac_code  <= '0;
                        cnt       <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt == SAMPLE_LAST) begin
                        state    <= ST_TRIAL;
                        sample   <= 1'b0;
                        cnt      <= '0;
                        bit_idx  <= MSB_IDX;
                        dac_code <= {1'b1, {(WIDTH-1){1'b0}}};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_TRIAL: begin
                    if (cnt == TRIAL_LAST) begin
                        cnt      <= '0;
                        dac_code <= trial_next;
                        if (bit_idx == '0) begin
                            state <= ST_DONE;
                        end else begin
                            bit_idx <= bit_idx - 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    result    <= dac_code;
                    result_ch <= mux_sel;
                    done      <= 1'b1;
                    if (scan_go) begin
                        state     <= ST_SAMPLE;
                        mux_sel   <= next_ch(mux_sel);
                        sample    <= 1'b1;
                        dac_code  <= '0;
                        cnt       <= '0;
                        scan_stop <= 1'b0;
                    end else begin
                        state    <= ST_IDLE;
                        scan_act <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_seq.sv
// Self-checking bench for sar_adc_seq: table-driven single conversions
// against an ideal comparator model, plus hand-written reset, invalid
// channel and (with SAR_SCAN_MODE_EN) scan sequences.
module tb_sar_adc_seq;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       start3;
    logic [1:0] ch_sel;
    logic       scan_en;
    logic       cmp_in;

    logic [7:0] dac_code;
    logic [1:0] mux_sel;
    logic       sample;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [1:0] result_ch;

    logic [7:0] dac_code3;
    logic [1:0] mux_sel3;
    logic       sample3;
    logic       busy3;
    logic       done3;
    logic [7:0] result3;
    logic [1:0] result_ch3;

    logic [7:0] vin_ch [4];

    int checks = 0;
    int errors = 0;
    int busy_seen;

    // Ideal comparator: input of the selected channel against the DAC level.
    assign cmp_in = (vin_ch[mux_sel] >= dac_code);

    sar_adc_seq dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .ch_sel(ch_sel),
        .scan_en(scan_en), .cmp_in(cmp_in), .dac_code(dac_code), .mux_sel(mux_sel),
        .sample(sample), .busy(busy), .done(done), .result(result), .result_ch(result_ch)
    );

    sar_adc_seq #(.CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start3), .ch_sel(ch_sel),
        .scan_en(1'b0), .cmp_in(cmp_in), .dac_code(dac_code3), .mux_sel(mux_sel3),
        .sample(sample3), .busy(busy3), .done(done3), .result(result3), .result_ch(result_ch3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vin;
        logic [1:0] ch;
        logic [7:0] exp_res;
        logic [1:0] exp_ch;
        int         exp_lat;
        int         pa;
        int         pb;
        int         eo;
        int         el;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One conversion: pa/pb are extra start pulses, ena low for el cycles from eo.
    task automatic run_conv(input logic [7:0] v, input logic [1:0] ch,
                            input int pa, input int pb, input int eo, input int el,
                            output int lat);
        @(negedge clk);
        vin_ch[ch] = v;
        ch_sel     = ch;
        start      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        busy_seen = int'(busy);
        lat       = 0;
        while (!done && lat < 100) begin
            start = (lat == pa) || (lat == pb);
            ena   = !((lat >= eo) && (lat < eo + el));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        ena   = 1'b1;
    endtask

    task automatic watch(input int n, output int dones, output int busys, output int dones3, output int busys3);
        dones = 0; busys = 0; dones3 = 0; busys3 = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            dones  += int'(done);
            busys  += int'(busy);
            dones3 += int'(done3);
            busys3 += int'(busy3);
        end
    endtask

    initial begin
        int lat;
        int nd, nb, nd3, nb3;

        vecs[0] = '{8'hA5, 2'd2, 8'hA5, 2'd2, 35, -1, -1, -1, 0};
        vecs[1] = '{8'hFF, 2'd0, 8'hFF, 2'd0, 35, -1, -1, -1, 0};
        vecs[2] = '{8'h00, 2'd3, 8'h00, 2'd3, 35, -1, -1, -1, 0};
        vecs[3] = '{8'h5A, 2'd1, 8'h5A, 2'd1, 35, -1, -1, -1, 0};
        vecs[4] = '{8'h3C, 2'd1, 8'h3C, 2'd1, 35,  5, 20, -1, 0};
        vecs[5] = '{8'h81, 2'd3, 8'h81, 2'd3, 42, -1, -1, 12, 7};
        vecs[6] = '{8'h01, 2'd0, 8'h01, 2'd0, 35, -1, -1, -1, 0};

        for (int k = 0; k < 4; k++) vin_ch[k] = 8'h00;
        rst_n   = 1'b0;
        ena     = 1'b1;
        start   = 1'b1;
        start3  = 1'b0;
        ch_sel  = 2'd1;
        scan_en = 1'b0;

        // Reset held three cycles with start asserted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset dac_code", 32'(dac_code), 32'h0);
        chk("reset mux_sel", 32'(mux_sel), 32'h0);
        chk("reset sample", 32'(sample), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset result", 32'(result), 32'h0);
        chk("reset result_ch", 32'(result_ch), 32'h0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_conv(vecs[i].vin, vecs[i].ch, vecs[i].pa, vecs[i].pb, vecs[i].eo, vecs[i].el, lat);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d busy after accept", i), 32'(busy_seen), 32'h1);
            chk($sformatf("v%0d result", i), 32'(result), 32'(vecs[i].exp_res));
            chk($sformatf("v%0d result_ch", i), 32'(result_ch), 32'(vecs[i].exp_ch));
            watch(40, nd, nb, nd3, nb3);
            chk($sformatf("v%0d extra done", i), 32'(nd), 32'h0);
            chk($sformatf("v%0d busy after done", i), 32'(nb), 32'h0);
            chk($sformatf("v%0d result held", i), 32'(result), 32'(vecs[i].exp_res));
        end

        // Reset in the middle of a conversion discards it.
        @(negedge clk);
        vin_ch[2] = 8'h77;
        ch_sel    = 2'd2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midreset busy before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset busy", 32'(busy), 32'h0);
        chk("midreset result", 32'(result), 32'h0);
        chk("midreset dac_code", 32'(dac_code), 32'h0);
        chk("midreset sample", 32'(sample), 32'h0);
        watch(50, nd, nb, nd3, nb3);
        chk("midreset no done", 32'(nd), 32'h0);
        chk("midreset stays idle", 32'(nb), 32'h0);

        // Out-of-range channel on a 3-channel instance is ignored.
        @(negedge clk);
        ch_sel = 2'd3;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        watch(50, nd, nb, nd3, nb3);
        chk("badch busy", 32'(nb3), 32'h0);
        chk("badch done", 32'(nd3), 32'h0);
        chk("badch mux_sel", 32'(mux_sel3), 32'h0);

`ifdef SAR_SCAN_MODE_EN
        // Scan all channels; drop scan_en during the fifth conversion.
        vin_ch[0] = 8'h10; vin_ch[1] = 8'h20; vin_ch[2] = 8'h30; vin_ch[3] = 8'h40;
        @(negedge clk);
        ch_sel  = 2'd3;
        scan_en = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            lat = 0;
            while (!done && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("scan%0d done seen", n), 32'(done), 32'h1);
            chk($sformatf("scan%0d result_ch", n), 32'(result_ch), 32'(n % 4));
            chk($sformatf("scan%0d result", n), 32'(result), 32'(8'h10 * ((n % 4) + 1)));
            if (n == 3) scan_en = 1'b0;
            @(negedge clk);
        end
        watch(50, nd, nb, nd3, nb3);
        chk("scan stop done", 32'(nd), 32'h0);
        chk("scan stop busy", 32'(nb), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
